// File: rtl/stream_pkg.sv
// Shared sizing helpers for the stream FIFO buffer and its register file.
package stream_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Occupancy must represent 0..depth inclusive, hence depth+1 codes.
    function automatic int unsigned level_w(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    function automatic bit is_pow2(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_fifo_regfile.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port, no reset.
module stream_fifo_regfile
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                        i_clk,
    input  logic                        i_we,
    input  logic [clog2(DEPTH)-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    input  logic [clog2(DEPTH)-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0]       o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo_buffer.sv
// Elastic stream buffer: register FIFO with registered in_ready, optional
// first-word fall-through bypass, occupancy output and synchronous flush.
module stream_fifo_buffer
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FALL_THROUGH = 1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("stream_fifo_buffer: DEPTH must be a power of two >= 2");
    end

    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic                   r_in_ready;

    logic                   w_empty;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_bypass;
    logic                   w_store;
    logic                   w_rd_mem;
    logic                   w_out_valid;
    logic [LW-1:0]          w_level_next;
    logic [DATA_WIDTH-1:0]  w_mem_rdata;

    always_comb begin
        w_empty     = (r_level == '0);
        w_wr        = in_valid & r_in_ready;
        w_out_valid = 1'b0;
        w_bypass    = 1'b0;
        if (FALL_THROUGH != 0) begin
            w_out_valid = ~flush & (~w_empty | w_wr);
            w_bypass    = w_empty & w_wr & out_ready;
        end else begin
            w_out_valid = ~flush & ~w_empty;
        end
        w_rd     = w_out_valid & out_ready;
        // A word accepted during flush is dropped, and a bypassed word never touches storage.
        w_store  = w_wr & ~w_bypass & ~flush;
        w_rd_mem = w_rd & ~w_empty;
        w_level_next = flush ? '0 : (r_level + LW'(w_store) - LW'(w_rd_mem));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_mem) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            r_level    <= w_level_next;
            r_in_ready <= ~flush & (w_level_next < FULL_LEVEL);
        end
    end

    stream_fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .i_clk   (aclk),
        .i_we    (w_store),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = ((FALL_THROUGH != 0) && w_empty) ? in_data : w_mem_rdata;
    assign level     = r_level;

    a_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(w_wr && (r_level == FULL_LEVEL)));

    a_no_underflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(w_rd && w_empty && !w_bypass));

endmodule

// File: tb/tb_stream_fifo_buffer.sv
// Scoreboard bench for stream_fifo_buffer: four instances (DEPTH 4/8 x FALL_THROUGH 1/0)
// share directed stimulus; a negedge monitor models ready/valid/level and checks word order.
module tb_stream_fifo_buffer;
    import stream_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  flush;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] in_data  [4];
    logic [31:0] out_data [4];
    logic [3:0]  level    [4];

    logic [31:0] exp_q [4][$];
    logic        exp_rdy  [4];
    int unsigned push_cnt [4];
    int unsigned pop_cnt  [4];
    int unsigned n_cmp;
    int unsigned n_err;

    // Index map: 0 = D4/FT1, 1 = D4/FT0, 2 = D8/FT1, 3 = D8/FT0
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned D = (g < 2) ? 4 : 8;
        localparam int unsigned F = (g % 2 == 0) ? 1 : 0;
        logic [level_w(D)-1:0] lv;
        stream_fifo_buffer #(
            .DATA_WIDTH   (32),
            .DEPTH        (D),
            .FALL_THROUGH (F)
        ) u_dut (
            .aclk      (clk),
            .aresetn   (rst_n),
            .flush     (flush[g]),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .level     (lv)
        );
        assign level[g] = 4'(lv);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned dep_of(input int g);
        return (g < 2) ? 4 : 8;
    endfunction

    function automatic bit ft_of(input int g);
        return (g % 2) == 0;
    endfunction

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        int unsigned lvl;
        logic        wr;
        logic        ov_exp;
        logic [31:0] d;
        for (int g = 0; g < 4; g++) begin
            if (!rst_n) begin
                check("rst_in_ready", g, 32'(in_ready[g]), 32'd0);
                check("rst_out_valid", g, 32'(out_valid[g]), 32'd0);
                check("rst_level", g, 32'(level[g]), 32'd0);
                exp_q[g].delete();
                exp_rdy[g] = 1'b0;
            end else begin
                lvl    = exp_q[g].size();
                wr     = in_valid[g] && exp_rdy[g];
                ov_exp = !flush[g] && ((lvl != 0) || (ft_of(g) && wr));
                check("in_ready", g, 32'(in_ready[g]), 32'(exp_rdy[g]));
                check("level", g, 32'(level[g]), lvl);
                check("out_valid", g, 32'(out_valid[g]), 32'(ov_exp));
                if (flush[g]) begin
                    exp_q[g].delete();
                end else begin
                    if (wr) begin
                        exp_q[g].push_back(in_data[g]);
                        push_cnt[g]++;
                    end
                    if (out_valid[g] && out_ready[g]) begin
                        check("q_nonempty", g, 32'(exp_q[g].size() != 0), 32'd1);
                        if (exp_q[g].size() != 0) begin
                            d = exp_q[g].pop_front();
                            check("out_data", g, out_data[g], d);
                        end
                        pop_cnt[g]++;
                    end
                end
                exp_rdy[g] = !flush[g] && (exp_q[g].size() < dep_of(g));
            end
        end
    end

    task automatic drive_rand(input int g);
        int unsigned base;
        int unsigned pbase;
        int unsigned guard;
        base  = push_cnt[g];
        pbase = pop_cnt[g];
        guard = 0;
        while ((push_cnt[g] - base) < 1000 && guard < 20000) begin
            in_valid[g]  = ($urandom_range(0, 1) == 1);
            in_data[g]   = 32'h5000_0000 + (32'(g) << 24) + (push_cnt[g] - base);
            out_ready[g] = ($urandom_range(0, 1) == 1);
            cyc();
            guard++;
        end
        in_valid[g] = 1'b0;
        check("t5_words_sent", g, push_cnt[g] - base, 32'd1000);
        out_ready[g] = 1'b1;
        guard = 0;
        while (exp_q[g].size() != 0 && guard < 50) begin
            cyc();
            guard++;
        end
        check("t5_words_received", g, pop_cnt[g] - pbase, 32'd1000);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int unsigned p0;
        int unsigned p2;
        n_cmp = 0;
        n_err = 0;
        for (int g = 0; g < 4; g++) begin
            push_cnt[g] = 0;
            pop_cnt[g]  = 0;
            exp_rdy[g]  = 1'b0;
            in_data[g]  = 32'hDEAD_0000 + 32'(g);
        end

        // 1: reset held three clocks with in_valid high
        rst_n     = 1'b0;
        flush     = '0;
        in_valid  = '1;
        out_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check("t1_ready_in_reset", g, 32'(in_ready[g]), 32'd0);
            check("t1_valid_in_reset", g, 32'(out_valid[g]), 32'd0);
        end
        rst_n    = 1'b1;
        in_valid = '0;
        cyc();
        for (int g = 0; g < 4; g++) check("t1_ready_after_rst", g, 32'(in_ready[g]), 32'd1);

        // 2: back-to-back stream 1..16 with downstream always ready
        out_ready = '1;
        p0 = pop_cnt[0];
        p2 = pop_cnt[2];
        for (int i = 1; i <= 16; i++) begin
            in_valid = '1;
            for (int g = 0; g < 4; g++) in_data[g] = 32'(i);
            #1;
            if (i == 5) begin
                check("t2_bypass_data", 0, out_data[0], 32'd5);
                check("t2_bypass_level", 0, 32'(level[0]), 32'd0);
            end
            cyc();
        end
        in_valid = '0;
        check("t2_ft_count", 0, pop_cnt[0] - p0, 32'd16);
        check("t2_ft_count", 2, pop_cnt[2] - p2, 32'd16);
        repeat (3) cyc();

        // 3: fill with downstream stalled, then release a single word
        out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid = '1;
            for (int g = 0; g < 4; g++) in_data[g] = 32'hA0 + 32'(i);
            cyc();
            for (int g = 0; g < 4; g++) check("t3_fill_level", g, 32'(level[g]), 32'(i + 1));
        end
        in_valid = '0;
        for (int g = 0; g < 4; g++) check("t3_ready_full", g, 32'(in_ready[g]), (dep_of(g) == 4) ? 32'd0 : 32'd1);
        out_ready = '1;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("t3_head_valid", g, 32'(out_valid[g]), 32'd1);
            check("t3_head_data", g, out_data[g], 32'hA0);
        end
        cyc();
        out_ready = '0;
        for (int g = 0; g < 4; g++) begin
            check("t3_level_after_read", g, 32'(level[g]), 32'd3);
            check("t3_ready_after_read", g, 32'(in_ready[g]), 32'd1);
        end
        out_ready = '1;
        repeat (6) cyc();

        // 4: single word into an empty buffer
        in_valid = '1;
        for (int g = 0; g < 4; g++) in_data[g] = 32'h55;
        #1;
        check("t4_no_early_valid", 1, 32'(out_valid[1]), 32'd0);
        check("t4_bypass_valid", 0, 32'(out_valid[0]), 32'd1);
        check("t4_bypass_data", 0, out_data[0], 32'h55);
        cyc();
        in_valid = '0;
        #1;
        check("t4_valid_latency", 1, 32'(out_valid[1]), 32'd1);
        check("t4_data", 1, out_data[1], 32'h55);
        check("t4_level_stored", 1, 32'(level[1]), 32'd1);
        check("t4_level_bypass", 0, 32'(level[0]), 32'd0);
        cyc();
        check("t4_level_drained", 1, 32'(level[1]), 32'd0);
        check("t4_valid_drained", 1, 32'(out_valid[1]), 32'd0);

        // 6: flush with three stored words and a concurrent write
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = '1;
            for (int g = 0; g < 4; g++) in_data[g] = 32'hB0 + 32'(i);
            cyc();
        end
        in_valid = '0;
        for (int g = 0; g < 4; g++) check("t6_level_before", g, 32'(level[g]), 32'd3);
        flush     = '1;
        in_valid  = '1;
        out_ready = '1;
        for (int g = 0; g < 4; g++) in_data[g] = 32'hBF;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("t6_valid_during_flush", g, 32'(out_valid[g]), 32'd0);
            check("t6_ready_during_flush", g, 32'(in_ready[g]), 32'd1);
        end
        cyc();
        flush    = '0;
        in_valid = '0;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("t6_level_after", g, 32'(level[g]), 32'd0);
            check("t6_valid_after", g, 32'(out_valid[g]), 32'd0);
            check("t6_ready_after", g, 32'(in_ready[g]), 32'd0);
        end
        cyc();
        for (int g = 0; g < 4; g++) check("t6_ready_recovered", g, 32'(in_ready[g]), 32'd1);
        in_valid = '1;
        for (int g = 0; g < 4; g++) in_data[g] = 32'hC0;
        cyc();
        in_valid = '0;
        repeat (3) cyc();

        // 5: independent random valid/ready, 1000 words per instance
        fork
            drive_rand(0);
            drive_rand(1);
            drive_rand(2);
            drive_rand(3);
        join
        repeat (2) cyc();
        for (int g = 0; g < 4; g++) check("final_queue_empty", g, exp_q[g].size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
